// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Responder side of the data-memory interface for the 64-bit datapath.
//   Accepts one load/store at a time over valid/ready, waits LATENCY cycles,
//   performs the access on a doubleword backing store and holds the response
//   until the requester consumes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   req_valid  request present
//   req_ready  responder can accept a request (high only in IDLE)
//   req_write  1 = store, 0 = load
//   req_addr   byte address; bits above ADDR_W+2 are ignored (address wraps)
//   req_wdata  store data
//   req_bmask  store byte enables, bit i enables byte i
//   rsp_valid  response present (high only in RESP)
//   rsp_ready  requester consumes the response
//   rsp_rdata  load data; 0 for stores and misaligned requests
//   rsp_error  misaligned address (req_addr[2:0] != 0)
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int SIZE    = 64,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SIZE-1:0]   req_addr,
  input  logic [SIZE-1:0]   req_wdata,
  input  logic [SIZE/8-1:0] req_bmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [SIZE-1:0]   rsp_rdata,
  output logic              rsp_error
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = SIZE / 8;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int AQ_W   = ADDR_W + 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  count;
  logic              wr_q;
  logic [AQ_W-1:0]   addr_q;
  logic [SIZE-1:0]   wdata_q;
  logic [NBYTES-1:0] bmask_q;

  logic              accept;
  logic              access;
  logic              misaligned;
  logic [ADDR_W-1:0] idx;

  // Address bits above the store's span are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[SIZE-1:AQ_W];

  // Backing store. Zero-initialised so simulation starts from known contents.
  logic [SIZE-1:0] mem [DEPTH] = '{default: '0};

  assign accept     = req_valid && req_ready;
  assign access     = (state == WAIT) && (count == '0);
  assign misaligned = (addr_q[2:0] != 3'b000);
  assign idx        = addr_q[AQ_W-1:3];

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = WAIT;
      end
      WAIT: begin
        if (count == '0) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, latency counter and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bmask_q   <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (accept) begin
        count   <= CNT_W'(LATENCY - 1);
        wr_q    <= req_write;
        addr_q  <= req_addr[AQ_W-1:0];
        wdata_q <= req_wdata;
        bmask_q <= req_bmask;
      end else if (state == WAIT && count != '0) begin
        count <= count - 1'b1;
      end

      if (access) begin
        rsp_error <= misaligned;
        // Loads see the doubleword as it stood before this edge.
        rsp_rdata <= (misaligned || wr_q) ? '0 : mem[idx];
      end else if (rsp_valid && rsp_ready) begin
        rsp_rdata <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Backing store write port
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset; a reset cannot complete a pending
  // store because it forces the FSM out of WAIT before the access edge.
  always_ff @(posedge clk) begin
    if (access && wr_q && !misaligned) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bmask_q[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Scoreboarded bench for data_mem_responder. The main instance uses the
//   default parameters (LATENCY=2); a second instance runs LATENCY=1.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_bmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  logic        l1_req_valid = 1'b0;
  logic        l1_req_ready;
  logic        l1_req_write = 1'b0;
  logic [63:0] l1_req_addr  = '0;
  logic [63:0] l1_req_wdata = '0;
  logic [7:0]  l1_req_bmask = '0;
  logic        l1_rsp_valid;
  logic        l1_rsp_ready = 1'b0;
  logic [63:0] l1_rsp_rdata;
  logic        l1_rsp_error;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc;

  exp_t        sb[$];
  logic [63:0] model [256];

  data_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_bmask (req_bmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error)
  );

  data_mem_responder #(.LATENCY(1)) dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (l1_req_valid),
    .req_ready (l1_req_ready),
    .req_write (l1_req_write),
    .req_addr  (l1_req_addr),
    .req_wdata (l1_req_wdata),
    .req_bmask (l1_req_bmask),
    .rsp_valid (l1_rsp_valid),
    .rsp_ready (l1_rsp_ready),
    .rsp_rdata (l1_rsp_rdata),
    .rsp_error (l1_rsp_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive a request, push its expected response, return after the accept edge.
  task automatic issue(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                       input logic [7:0] bm);
    exp_t e;
    int   n;
    logic [7:0] ix;
    ix = a[10:3];
    if (a[2:0] != 3'b000) begin
      e.rdata = '0; e.err = 1'b1;
    end else if (wr) begin
      for (int b = 0; b < 8; b++)
        if (bm[b]) model[ix][b*8 +: 8] = wd[b*8 +: 8];
      e.rdata = '0; e.err = 1'b0;
    end else begin
      e.rdata = model[ix]; e.err = 1'b0;
    end
    sb.push_back(e);

    req_write = wr; req_addr = a; req_wdata = wd; req_bmask = bm;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL issue_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
    end
    @(posedge clk); #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    // Scramble the inputs: the DUT must have captured them at the accept edge.
    req_write = ~wr; req_addr = {$urandom, $urandom}; req_wdata = ~wd; req_bmask = 8'hFF;
  endtask

  // Wait for the response, check latency, compare against the scoreboard.
  task automatic collect(output logic [63:0] rd, output logic er);
    exp_t e;
    int   n;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    rd = rsp_rdata; er = rsp_error;
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required 1", n);
      return;
    end
    checks++;
    if (cyc - acc_cyc != LAT) begin
      errors++;
      $display("FAIL latency: got %0d edges, required %0d", cyc - acc_cyc, LAT);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: response with no expectation");
      return;
    end
    e = sb.pop_front();
    if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
      errors++;
      $display("FAIL rsp_data: rdata=%h err=%0b, required rdata=%h err=%0b",
               rsp_rdata, rsp_error, e.rdata, e.err);
    end
  endtask

  // Complete the response handshake and check the post-handshake state.
  task automatic consume;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL consume: rsp_valid=%0b rsp_rdata=%h req_ready=%0b, required 0 0 1",
               rsp_valid, rsp_rdata, req_ready);
    end
  endtask

  task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                     input logic [7:0] bm, output logic [63:0] rd, output logic er);
    issue(wr, a, wd, bm);
    collect(rd, er);
    consume();
  endtask

  task automatic test_reset;
    logic [63:0] rd;
    logic        er;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: req_ready=%0b rsp_valid=%0b rdata=%h err=%0b, required 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_error);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    txn(1'b1, 64'h10, 64'h0, 8'hFF, rd, er);

    // Store that reset must discard; not pushed to the scoreboard or model.
    req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hAAAA_AAAA_AAAA_AAAA; req_bmask = 8'hFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: req_ready=%0b, required 0", req_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL async_reset: req_ready=%0b rsp_valid=%0b rdata=%h, required 1 0 0",
               req_ready, rsp_valid, rsp_rdata);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    txn(1'b0, 64'h10, 64'h0, 8'h00, rd, er);
    checks++;
    if (rd !== 64'h0) begin
      errors++;
      $display("FAIL reset_discard: load 0x10 got %h, required 0", rd);
    end
  endtask

  task automatic test_store_load;
    logic [63:0] rd;
    logic        er;
    txn(1'b1, 64'h18, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er);
    txn(1'b0, 64'h18, 64'h0, 8'h00, rd, er);
    checks++;
    if (rd !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL store_load: got %h, required 0123456789abcdef", rd);
    end
  endtask

  task automatic test_bytemask;
    logic [63:0] rd;
    logic        er;
    txn(1'b1, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rd, er);
    txn(1'b0, 64'h18, 64'h0, 8'h00, rd, er);
    checks++;
    if (rd !== 64'h0123_4567_FFFF_FFFF) begin
      errors++;
      $display("FAIL bytemask: got %h, required 01234567ffffffff", rd);
    end
    // Empty mask completes with no change.
    txn(1'b1, 64'h18, 64'h0, 8'h00, rd, er);
    txn(1'b0, 64'h18, 64'h0, 8'h00, rd, er);
    checks++;
    if (rd !== 64'h0123_4567_FFFF_FFFF) begin
      errors++;
      $display("FAIL bytemask_zero: got %h, required 01234567ffffffff", rd);
    end
  endtask

  task automatic test_misaligned;
    logic [63:0] rd;
    logic        er;
    txn(1'b0, 64'h1C, 64'h0, 8'h00, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 64'h0) begin
      errors++;
      $display("FAIL misaligned_load: err=%0b rdata=%h, required 1 0", er, rd);
    end
    txn(1'b1, 64'h1A, 64'h0, 8'hFF, rd, er);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_store: err=%0b, required 1", er);
    end
    txn(1'b0, 64'h18, 64'h0, 8'h00, rd, er);
    checks++;
    if (rd !== 64'h0123_4567_FFFF_FFFF || er !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_nostore: got %h err=%0b, required 01234567ffffffff 0", rd, er);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] rd;
    logic        er;
    int          hs_cyc;
    issue(1'b0, 64'h18, 64'h0, 8'h00);
    collect(rd, er);
    // A second request waits while the response is held.
    req_write = 1'b0; req_addr = 64'h18; req_bmask = 8'h00; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0123_4567_FFFF_FFFF ||
          rsp_error !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%0b rdata=%h err=%0b req_ready=%0b, required 1 01234567ffffffff 0 0",
                 i, rsp_valid, rsp_rdata, rsp_error, req_ready);
      end
    end
    consume();
    hs_cyc = cyc;
    issue(1'b0, 64'h18, 64'h0, 8'h00);
    checks++;
    if (acc_cyc != hs_cyc + 1) begin
      errors++;
      $display("FAIL backpressure_accept: accepted %0d cycles after handshake, required 1",
               acc_cyc - hs_cyc);
    end
    collect(rd, er);
    consume();
  endtask

  task automatic l1_txn(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output int lat);
    int start;
    l1_req_write = wr; l1_req_addr = a; l1_req_wdata = wd; l1_req_bmask = 8'hFF;
    l1_req_valid = 1'b1;
    @(posedge clk); #1;
    l1_req_valid = 1'b0;
    start = cyc;
    lat = 0;
    while (!l1_rsp_valid && cyc - start < 50) begin @(posedge clk); #1; end
    lat = cyc - start;
    rd  = l1_rsp_rdata;
    l1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    l1_rsp_ready = 1'b0;
  endtask

  task automatic test_wrap_latency1;
    logic [63:0] rd;
    logic        er;
    int          lat;
    txn(1'b1, 64'h800, 64'h55, 8'hFF, rd, er);
    txn(1'b0, 64'h0, 64'h0, 8'h00, rd, er);
    checks++;
    if (rd !== 64'h55) begin
      errors++;
      $display("FAIL wrap: load 0x0 got %h, required 55", rd);
    end

    l1_txn(1'b1, 64'h20, 64'h77, rd, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL latency1_store: got %0d edges, required 1", lat);
    end
    l1_txn(1'b0, 64'h20, 64'h0, rd, lat);
    checks++;
    if (lat != 1 || rd !== 64'h77) begin
      errors++;
      $display("FAIL latency1_load: lat=%0d rdata=%h, required 1 77", lat, rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    test_reset();
    test_store_load();
    test_bytemask();
    test_misaligned();
    test_backpressure();
    test_wrap_latency1();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
